tick_scheduler: RTL and testbench

//  Replaces free-running per-consumer CLOCK dividers with one shared prescaler.

---
 rtl/tick_sched_pkg.sv | 16 +
 rtl/tick_channel.sv | 82 ++++++++
 rtl/tick_scheduler.sv | 76 +++++++
 tb/tb_tick_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared types for the tick scheduler: divisor type, "disabled" divisor value
// and the per-channel run state.
package tick_sched_pkg;

  localparam int unsigned DEF_DIV_W = 16;

  typedef logic [DEF_DIV_W-1:0] div_t;

  localparam div_t DIV_OFF = '0;

  typedef enum logic {
    OFF = 1'b0,
    RUN = 1'b1
  } chan_state_e;

endpackage

// File: rtl/tick_channel.sv
// One programmable tick channel: divides the shared base tick by a run-time
// divisor; new divisors only take effect at a period boundary (SLOW_TOGGLE_EN adds a square wave).
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             base_tick,
  input  logic             load,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick,
  output logic             active,
  output logic             pending
`ifdef SLOW_TOGGLE_EN
  ,
  output logic             slow
`endif
);

  localparam logic [DIV_W-1:0] OFF_DIV = DIV_W'(DIV_OFF);

  chan_state_e      state;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] new_div;
  logic             wrap;
  logic             boundary;

  // wrap is never true while OFF because div-1 wraps to all ones and cnt is held at 0
  assign wrap     = (state == RUN) && (cnt == div - DIV_W'(1));
  assign boundary = (state == OFF) || wrap;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state   <= OFF;
      div     <= OFF_DIV;
      cnt     <= '0;
      new_div <= OFF_DIV;
      pending <= 1'b0;
      tick    <= 1'b0;
      active  <= 1'b0;
`ifdef SLOW_TOGGLE_EN
      slow    <= 1'b0;
`endif
    end else begin
      tick <= 1'b0;
      // load is only issued while pending is clear, so it never races the apply below
      if (load) begin
        new_div <= cfg_div;
        pending <= 1'b1;
      end
      if (base_tick) begin
        if (state == RUN) begin
          if (wrap) begin
            tick <= 1'b1;
            cnt  <= '0;
`ifdef SLOW_TOGGLE_EN
            slow <= ~slow;
`endif
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        if (pending && boundary) begin
          div     <= new_div;
          cnt     <= '0;
          pending <= 1'b0;
          active  <= (new_div != OFF_DIV);
          state   <= (new_div != OFF_DIV) ? RUN : OFF;
`ifdef SLOW_TOGGLE_EN
          if (new_div == OFF_DIV) begin
            slow <= 1'b0;
          end
`endif
        end
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Shared prescaler feeding N_CH programmable tick channels with a per-channel
// config handshake. Define SLOW_TOGGLE_EN to add the SLOW square-wave outputs.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned DIV_W    = DEF_DIV_W
) (
  input  logic                                   CLOCK,
  input  logic                                   RESET,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_chan,
  input  logic [DIV_W-1:0]                       cfg_div,
  output logic [N_CH-1:0]                        tick,
  output logic [N_CH-1:0]                        active
`ifdef SLOW_TOGGLE_EN
  ,
  output logic [N_CH-1:0]                        SLOW
`endif
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PW   = $clog2(PRESCALE);
  localparam int unsigned NSEL = 1 << CH_W;

  logic [PW-1:0]   pre;
  logic            base_tick;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] load;
  logic [NSEL-1:0] ready_vec;

  assign base_tick = (pre == PW'(PRESCALE - 1));

  always_ff @(posedge CLOCK) begin
    if (RESET || base_tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // Unused channel codes always read ready so such writes are swallowed.
  for (genvar i = 0; i < NSEL; i++) begin : g_ready
    if (i < N_CH) begin : g_live
      assign ready_vec[i] = ~pending[i];
    end else begin : g_pad
      assign ready_vec[i] = 1'b1;
    end
  end

  assign cfg_ready = ready_vec[cfg_chan];

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    assign load[i] = cfg_valid && cfg_ready && (cfg_chan == CH_W'(i));

    tick_channel #(
      .DIV_W(DIV_W)
    ) u_chan (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .base_tick(base_tick),
      .load     (load[i]),
      .cfg_div  (cfg_div),
      .tick     (tick[i]),
      .active   (active[i]),
      .pending  (pending[i])
`ifdef SLOW_TOGGLE_EN
      ,
      .slow     (SLOW[i])
`endif
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: directed scenarios plus random config
// writes, all checked against an absolute-time reference model.
module tb_tick_scheduler;

  localparam int PRESCALE = 4;
  localparam int N_CH     = 4;
  localparam int DIV_W    = 8;

  logic             CLOCK = 1'b0;
  logic             RESET = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_chan = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  active;
`ifdef SLOW_TOGGLE_EN
  logic [N_CH-1:0]  slow;
`endif

  tick_scheduler #(
    .N_CH    (N_CH),
    .PRESCALE(PRESCALE),
    .DIV_W   (DIV_W)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .tick     (tick),
    .active   (active)
`ifdef SLOW_TOGGLE_EN
    ,
    .SLOW     (slow)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: k counts cycles since reset release; next_b is the absolute
  // cycle of the base tick that closes the current period.
  int         k;
  int         m_div  [N_CH];
  int         m_next [N_CH];
  int         m_pdiv [N_CH];
  bit         m_pend [N_CH];
  logic [3:0] m_slow;
  int         tick_log [N_CH][$];
  int         last_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    k = 0;
    m_slow = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_div[c] = 0; m_next[c] = 0; m_pdiv[c] = 0; m_pend[c] = 1'b0;
      tick_log[c].delete();
    end
  endtask

  // One clock cycle with the currently driven inputs; checks ready now, outputs after the edge.
  task automatic cycle(output bit acc);
    logic [3:0] exp_tick;
    logic [3:0] exp_active;
    logic       exp_rdy;
    bit         fire;
    int         ch;
    #1;
    ch = int'(cfg_chan);
    exp_rdy = !m_pend[ch];
    check("cfg_ready", 32'(cfg_ready), 32'(exp_rdy));
    acc = cfg_valid && exp_rdy;
    exp_tick = '0;
    if ((k % PRESCALE) == PRESCALE - 1) begin
      for (int c = 0; c < N_CH; c++) begin
        fire = (m_div[c] != 0) && (k == m_next[c]);
        if (fire) begin
          exp_tick[c] = 1'b1;
          m_next[c] = k + m_div[c] * PRESCALE;
          m_slow[c] = ~m_slow[c];
        end
        if (m_pend[c] && (m_div[c] == 0 || fire)) begin
          m_div[c]  = m_pdiv[c];
          m_pend[c] = 1'b0;
          m_next[c] = k + m_div[c] * PRESCALE;
          if (m_div[c] == 0) m_slow[c] = 1'b0;
        end
      end
    end
    if (acc) begin
      m_pend[ch] = 1'b1;
      m_pdiv[ch] = int'(cfg_div);
    end
    @(posedge CLOCK);
    #1;
    k++;
    for (int c = 0; c < N_CH; c++) begin
      exp_active[c] = (m_div[c] != 0);
      if (tick[c]) tick_log[c].push_back(k);
    end
    check("tick", 32'(tick), 32'(exp_tick));
    check("active", 32'(active), 32'(exp_active));
`ifdef SLOW_TOGGLE_EN
    check("slow", 32'(slow), 32'(m_slow));
`endif
  endtask

  task automatic idle(input int n);
    bit acc;
    cfg_valid = 1'b0;
    repeat (n) cycle(acc);
  endtask

  // Holds cfg_valid until the write is taken; last_hold = cycles spent waiting.
  task automatic cfg_write(input int ch, input int dv);
    bit acc;
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_chan  = 2'(ch);
    cfg_div   = DIV_W'(dv);
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < 200);
    if (!acc) check("cfg_write_timeout", 32'(acc), 32'(1));
    cfg_valid = 1'b0;
    last_hold = n - 1;
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    cfg_valid = 1'b0;
    repeat (n) @(posedge CLOCK);
    #1;
    check("rst_tick", 32'(tick), 32'(0));
    check("rst_active", 32'(active), 32'(0));
`ifdef SLOW_TOGGLE_EN
    check("rst_slow", 32'(slow), 32'(0));
`endif
    RESET = 1'b0;
    model_reset();
  endtask

  function automatic int total_ticks();
    int s;
    s = 0;
    for (int c = 0; c < N_CH; c++) s += tick_log[c].size();
    return s;
  endfunction

  initial begin
    int n, ka, both;
    bit acc;

    // reset state and silence without writes
    model_reset();
    do_reset(3);
    idle(200);
    check("idle_ticks", 32'(total_ticks()), 32'(0));

    // ch0 div=3: period 12
    cfg_write(0, 3);
    idle(60);
    check("s2_count", 32'(tick_log[0].size() >= 4), 32'(1));
    for (int i = 1; i < tick_log[0].size(); i++)
      check("s2_period", 32'(tick_log[0][i] - tick_log[0][i-1]), 32'(12));
    check("s2_active", 32'(active[0]), 32'(1));

    // mid-period change to div=5: old period completes, then 20
    tick_log[0].delete();
    n = 0;
    while (tick_log[0].size() == 0 && n < 100) begin idle(1); n++; end
    idle(4);
    cfg_write(0, 5);
    idle(70);
    check("s3_count", 32'(tick_log[0].size() >= 4), 32'(1));
    if (tick_log[0].size() >= 4) begin
      check("s3_first", 32'(tick_log[0][1] - tick_log[0][0]), 32'(12));
      check("s3_second", 32'(tick_log[0][2] - tick_log[0][1]), 32'(20));
      check("s3_third", 32'(tick_log[0][3] - tick_log[0][2]), 32'(20));
    end

    // back-to-back writes to ch1: second is held off
    cfg_write(1, 2);
    cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 8'd6;
    #1;
    check("s4_ready_low", 32'(cfg_ready), 32'(0));
    cfg_write(1, 6);
    check("s4_held", 32'(last_hold >= 1), 32'(1));
    idle(60);

    // accepts coinciding with base ticks on ch2 (div=1) and ch3 (div=2)
    tick_log[2].delete();
    tick_log[3].delete();
    n = 0;
    while ((k % PRESCALE) != PRESCALE - 1 && n < 8) begin idle(1); n++; end
    ka = k;
    cfg_write(2, 1);
    while ((k % PRESCALE) != PRESCALE - 1 && n < 16) begin idle(1); n++; end
    cfg_write(3, 2);
    idle(40);
    check("s5_ch2_first", 32'(tick_log[2].size() > 0 ? tick_log[2][0] : -1), 32'(ka + 9));
    check("s5_ch3_first", 32'(tick_log[3].size() > 0 ? tick_log[3][0] : -1), 32'(ka + 17));
    for (int i = 1; i < tick_log[2].size(); i++)
      check("s5_ch2_period", 32'(tick_log[2][i] - tick_log[2][i-1]), 32'(4));
    for (int i = 1; i < tick_log[3].size(); i++)
      check("s5_ch3_period", 32'(tick_log[3][i] - tick_log[3][i-1]), 32'(8));
    both = 0;
    foreach (tick_log[3][i])
      foreach (tick_log[2][j])
        if (tick_log[2][j] == tick_log[3][i]) both++;
    check("s5_coincident", 32'(both > 0), 32'(1));

    // random config traffic including disable and div=1
    for (int w = 0; w < 40; w++) begin
      cfg_write(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 6)));
      idle(int'($urandom_range(0, 15)));
    end
    idle(60);

    // reset mid-period with a pending write
    cfg_write(0, 5);
    idle(2);
    cfg_write(0, 2);
    cfg_chan = 2'd0;
    do_reset(1);
    check("s6_ready", 32'(cfg_ready), 32'(1));
    idle(80);
    check("s6_no_ticks", 32'(total_ticks()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
